// File: rtl/muldiv_pkg.sv
// Shared decode constants and FSM encoding for the multi-cycle mul/div sequencer.
package muldiv_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;

  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/muldiv_iter_core.sv
// Magnitude datapath: one left-shift/add multiply step or one restoring divide step per cycle.
// With MULDIV_EARLY_TERM_EN defined, mul_zero flags an exhausted multiplier.
module muldiv_iter_core #(
  parameter int NB = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic          op_is_div,
  input  logic [NB-1:0] a_mag,
  input  logic [NB-1:0] b_mag,
  output logic [NB-1:0] part_hi,
  output logic [NB-1:0] part_lo,
  output logic          mul_zero
);

  // div: acc = {remainder, dividend/quotient}, mcand[NB-1:0] = divisor
  // mul: acc = running product, mcand = shifted multiplicand, mplier = shifted multiplier
  logic [2*NB-1:0] acc, acc_nxt, mcand, mcand_nxt;
  logic [NB-1:0]   mplier, mplier_nxt;
  logic [NB:0]     rem_sh, diff;

  always_comb begin
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    rem_sh     = {acc[2*NB-1:NB], acc[NB-1]};
    diff       = rem_sh - {1'b0, mcand[NB-1:0]};
    if (op_is_div) begin
      if (!diff[NB]) acc_nxt = {diff[NB-1:0], acc[NB-2:0], 1'b1};
      else           acc_nxt = {rem_sh[NB-1:0], acc[NB-2:0], 1'b0};
    end else begin
      if (mplier[0]) acc_nxt = acc + mcand;
      mcand_nxt  = mcand << 1;
      mplier_nxt = mplier >> 1;
    end
  end

  assign part_hi = acc_nxt[2*NB-1:NB];
  assign part_lo = acc_nxt[NB-1:0];

`ifdef MULDIV_EARLY_TERM_EN
  assign mul_zero = (mplier_nxt == '0);
`else
  assign mul_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= op_is_div ? {{NB{1'b0}}, a_mag} : '0;
      mcand  <= {{NB{1'b0}}, (op_is_div ? b_mag : a_mag)};
      mplier <= b_mag;
    end else if (step) begin
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
    end
  end

endmodule

// File: rtl/muldiv_controller.sv
// HI/LO owner and sequencer for MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes.
// Optional MULDIV_EARLY_TERM_EN: multiplies finish once the multiplier is exhausted.
module muldiv_controller
  import muldiv_pkg::*;
#(
  parameter int NB        = 32,
  parameter int NB_FCODE  = 6,
  parameter int NB_OPCODE = 6,
  parameter int NB_CNT    = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic                 i_flush,
  input  logic [NB_OPCODE-1:0] i_instruction_op_code,
  input  logic [NB_FCODE-1:0]  i_instruction_funct_code,
  input  logic [NB-1:0]        i_data_a,
  input  logic [NB-1:0]        i_data_b,
  output logic                 o_stall,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_div_by_zero,
  output logic [NB-1:0]        o_hi,
  output logic [NB-1:0]        o_lo
);

  localparam logic [NB_CNT-1:0] CNT_LOAD = NB_CNT'(NB);
  localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

  logic [1:0]        state;
  logic [NB_CNT-1:0] cnt;
  logic              op_div, neg_q, neg_r, dz;
  logic [NB-1:0]     hi, lo;

  logic is_rtype, dec_mul_s, dec_mul_u, dec_div_s, dec_div_u, dec_div, dec_sgn;
  logic dec_muldiv, dec_mthi, dec_mtlo, req, accept, last;

  assign is_rtype   = (i_instruction_op_code == OPCODE_RTYPE);
  assign dec_mul_s  = is_rtype & (i_instruction_funct_code == FUNCT_MULT);
  assign dec_mul_u  = is_rtype & (i_instruction_funct_code == FUNCT_MULTU);
  assign dec_div_s  = is_rtype & (i_instruction_funct_code == FUNCT_DIV);
  assign dec_div_u  = is_rtype & (i_instruction_funct_code == FUNCT_DIVU);
  assign dec_mthi   = is_rtype & (i_instruction_funct_code == FUNCT_MTHI);
  assign dec_mtlo   = is_rtype & (i_instruction_funct_code == FUNCT_MTLO);
  assign dec_div    = dec_div_s | dec_div_u;
  assign dec_sgn    = dec_mul_s | dec_div_s;
  assign dec_muldiv = dec_mul_s | dec_mul_u | dec_div;

  assign req    = (state == IDLE) & i_valid & ~i_flush;
  assign accept = req & dec_muldiv;

  assign o_stall       = accept | (state == BUSY);
  assign o_busy        = (state == BUSY);
  assign o_done        = (state == DONE);
  assign o_div_by_zero = (state == DONE) & dz;
  assign o_hi          = hi;
  assign o_lo          = lo;

  logic          sign_a, sign_b, core_div, mul_zero;
  logic [NB-1:0] a_mag, b_mag, part_hi, part_lo;

  assign sign_a   = dec_sgn & i_data_a[NB-1];
  assign sign_b   = dec_sgn & i_data_b[NB-1];
  assign a_mag    = sign_a ? -i_data_a : i_data_a;
  assign b_mag    = sign_b ? -i_data_b : i_data_b;
  assign core_div = (state == IDLE) ? dec_div : op_div;

  muldiv_iter_core #(.NB(NB)) u_core (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .load      (accept),
    .step      (state == BUSY),
    .op_is_div (core_div),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .part_hi   (part_hi),
    .part_lo   (part_lo),
    .mul_zero  (mul_zero)
  );

  // Sign fix-up applied to the combinational result of the final step
  logic [2*NB-1:0] prod_raw, prod_fix;
  logic [NB-1:0]   quo_fix, rem_fix, commit_hi, commit_lo;

  assign prod_raw  = {part_hi, part_lo};
  assign prod_fix  = neg_q ? -prod_raw : prod_raw;
  assign quo_fix   = dz ? '1 : (neg_q ? -part_lo : part_lo);
  assign rem_fix   = neg_r ? -part_hi : part_hi;
  assign commit_hi = op_div ? rem_fix : prod_fix[2*NB-1:NB];
  assign commit_lo = op_div ? quo_fix : prod_fix[NB-1:0];
  assign last      = (cnt == CNT_ONE) | (~op_div & mul_zero);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= BUSY;
            cnt    <= CNT_LOAD;
            op_div <= dec_div;
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            dz     <= dec_div & ~|i_data_b;
          end else if (req & dec_mthi) begin
            hi <= i_data_a;
          end else if (req & dec_mtlo) begin
            lo <= i_data_a;
          end
        end
        BUSY: begin
          if (i_flush) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
            if (last) begin
              state <= DONE;
              hi    <= commit_hi;
              lo    <= commit_lo;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed-vector bench for muldiv_controller; latency expectations follow MULDIV_EARLY_TERM_EN.
module tb_muldiv_controller;
  import muldiv_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_flush = 1'b0;
  logic [5:0]  i_op = 6'h00;
  logic [5:0]  i_funct = 6'h00;
  logic [31:0] i_data_a = '0;
  logic [31:0] i_data_b = '0;
  logic        o_stall, o_busy, o_done, o_div_by_zero;
  logic [31:0] o_hi, o_lo;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  muldiv_controller dut (
    .i_clk                    (i_clk),
    .i_rst_n                  (i_rst_n),
    .i_valid                  (i_valid),
    .i_flush                  (i_flush),
    .i_instruction_op_code    (i_op),
    .i_instruction_funct_code (i_funct),
    .i_data_a                 (i_data_a),
    .i_data_b                 (i_data_b),
    .o_stall                  (o_stall),
    .o_busy                   (o_busy),
    .o_done                   (o_done),
    .o_div_by_zero            (o_div_by_zero),
    .o_hi                     (o_hi),
    .o_lo                     (o_lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle index of o_done relative to the accept cycle (cycle 0)
  function automatic int exp_done_cyc(input logic [5:0] f, input logic [31:0] b);
    int n;
    logic [31:0] m;
    n = 32;
    m = b;
`ifdef MULDIV_EARLY_TERM_EN
    if (f == FUNCT_MULT || f == FUNCT_MULTU) begin
      if (f == FUNCT_MULT && b[31]) m = -b;
      n = 0;
      while (m != 0) begin
        n++;
        m = m >> 1;
      end
      if (n == 0) n = 1;
    end
`endif
    return n + 1;
  endfunction

  // Called just after the edge that starts cycle 1; stops at the o_done negedge
  task automatic wait_done(output int cyc, output int stalls);
    logic got;
    got = 1'b0;
    cyc = 0;
    stalls = 0;
    while (!got && cyc < 100) begin
      cyc++;
      @(negedge i_clk);
      if (o_done) got = 1'b1;
      else stalls += int'(o_stall);
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz);
    int cyc, stalls, exp_cyc;
    exp_cyc = exp_done_cyc(f, b);
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_funct = f; i_data_a = a; i_data_b = b;
    @(negedge i_clk);
    chk({tag, ".stall_c0"}, 64'(o_stall), 64'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    wait_done(cyc, stalls);
    chk({tag, ".done_cyc"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, ".stall_cycles"}, 64'(stalls + 1), 64'(exp_cyc));
    chk({tag, ".stall_at_done"}, 64'(o_stall), 64'd0);
    chk({tag, ".dz"}, 64'(o_div_by_zero), 64'(edz));
    chk({tag, ".hi_lo"}, {o_hi, o_lo}, {ehi, elo});
  endtask

  initial begin
    int cyc, stalls;
    logic seen;
    logic [31:0] bflush;

    // Reset state
    #12;
    chk("reset.flags", 64'({o_stall, o_busy, o_done, o_div_by_zero}), 64'd0);
    chk("reset.hi_lo", {o_hi, o_lo}, 64'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    run_op("multu_7x6",   FUNCT_MULTU, 32'd7, 32'd6, 32'h0, 32'd42, 1'b0);
    run_op("mult_m3x5",   FUNCT_MULT, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("div_m7d2",    FUNCT_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_10d0",   FUNCT_DIVU, 32'd10, 32'd0, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1);
    run_op("div_m5d0",    FUNCT_DIV, -32'sd5, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    run_op("div_min_m1",  FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("multu_max",   FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
    run_op("mult_min2",   FUNCT_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    run_op("multu_9x1",   FUNCT_MULTU, 32'd9, 32'd1, 32'h0, 32'd9, 1'b0);

    // MTHI / MTLO: no stall, visible next cycle
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_funct = FUNCT_MTHI; i_data_a = 32'h1234;
    @(negedge i_clk);
    chk("mthi.stall", 64'(o_stall), 64'd0);
    @(posedge i_clk); #1;
    i_funct = FUNCT_MTLO; i_data_a = 32'h5678;
    @(negedge i_clk);
    chk("mthi.hi", 64'(o_hi), 64'h1234);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("mtlo.lo", 64'(o_lo), 64'h5678);

    // Flush during BUSY at cycle 10
`ifdef MULDIV_EARLY_TERM_EN
    bflush = 32'h8000_0003;
`else
    bflush = 32'd3;
`endif
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_funct = FUNCT_MULTU; i_data_a = 32'd2; i_data_b = bflush;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (8) @(posedge i_clk);
    @(posedge i_clk); #1;
    i_flush = 1'b1;
    @(negedge i_clk);
    chk("flush.busy_c10", 64'(o_busy), 64'd1);
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    @(negedge i_clk);
    chk("flush.stall_c11", 64'(o_stall), 64'd0);
    chk("flush.hi_lo", {o_hi, o_lo}, {32'h1234, 32'h5678});
    seen = 1'b0;
    repeat (40) begin
      @(negedge i_clk);
      seen |= o_done;
    end
    chk("flush.no_done", 64'(seen), 64'd0);

    // Back-to-back: DIVU held valid through DONE is only accepted afterwards
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_funct = FUNCT_DIV; i_data_a = 32'd100; i_data_b = 32'd7;
    @(posedge i_clk); #1;
    i_funct = FUNCT_DIVU; i_data_a = 32'd50; i_data_b = 32'd5;
    wait_done(cyc, stalls);
    chk("b2b.done_cyc", 64'(cyc), 64'd33);
    chk("b2b.stall_at_done", 64'(o_stall), 64'd0);
    chk("b2b.first_hi_lo", {o_hi, o_lo}, {32'd2, 32'd14});
    @(negedge i_clk);
    chk("b2b.accept_stall", 64'({o_stall, o_busy}), 64'b10);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    wait_done(cyc, stalls);
    chk("b2b.second_cyc", 64'(cyc), 64'd33);
    chk("b2b.second_hi_lo", {o_hi, o_lo}, {32'd0, 32'd10});

    // Asynchronous reset in BUSY cycle 5
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_funct = FUNCT_MULTU; i_data_a = 32'd7; i_data_b = 32'h8000_0000;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("rst.busy_c5", 64'(o_busy), 64'd1);
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst.async_flags", 64'({o_stall, o_busy, o_done, o_div_by_zero}), 64'd0);
    chk("rst.async_hi_lo", {o_hi, o_lo}, 64'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst.idle_after", 64'({o_stall, o_busy}), 64'd0);

    run_op("post_rst_multu", FUNCT_MULTU, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
